debounce_bank: RTL and testbench

- Parametrised multi-channel input conditioner for mechanical switches, buttons and rotary-encoder A/B contacts.
- Sits between the raw FPGA pins and the control logic.
- Per channel it provides:
  - 2-flop synchronisation
  - a shared programmable sample tick
  - an N-consecutive-sample stability filter
  - a registered debounced level plus one-cycle rise/fall strobes
- Generalises the fixed two-channel, single-compare debouncer to any channel count, sample rate and stability depth. Adds reset, enable and edge outputs.

---
 rtl/debounce_bank_if.sv | 49 ++++
 rtl/debounce_bank.sv | 158 +++++++++++++++
 tb/tb_debounce_bank.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// ---------------------------------------------------------------------------
// debounce_bank_if
//   Signal bundle between the input-conditioning bank and its user.
//
//   Parameters
//     N_CH        number of conditioned channels
//
//   Signals
//     en          filter enable (driven by the user)
//     din         raw asynchronous pin levels (driven by the user side / pins)
//     dout        debounced, registered levels
//     rise        one-clock strobe per channel when dout goes 0->1
//     fall        one-clock strobe per channel when dout goes 1->0
//     sample_tick one-clock pulse marking each sample instant
//
//   Modports
//     master      the side that drives en/din and consumes the results
//     slave       the debounce bank itself
// ---------------------------------------------------------------------------
interface debounce_bank_if #(
  parameter int N_CH = 2
);

  logic            en;
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] dout;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            sample_tick;

  modport master (
    output en,
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  sample_tick
  );

  modport slave (
    input  en,
    input  din,
    output dout,
    output rise,
    output fall,
    output sample_tick
  );

endinterface : debounce_bank_if

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Multi-channel input conditioner for switches, buttons and rotary-encoder
//   contacts. Every channel is synchronised through two flops, sampled on a
//   shared programmable tick, and only allowed to change its debounced level
//   after the new value has been seen on STABLE_SAMPLES consecutive ticks.
//   A change of the debounced level is accompanied by a one-clock rise or
//   fall strobe that coincides with the first cycle of the new level.
//
//   Parameters
//     N_CH            number of independent channels (1..32)
//     CLK_DIV         clk cycles per sample tick (>=1, 1 = every cycle)
//     STABLE_SAMPLES  consecutive ticks a new value must persist (>=1)
//     RST_VAL         reset/idle level of the sync flops and dout (0 or 1)
//
//   Ports
//     clk             system clock, all logic on its rising edge
//     rst_n           asynchronous active-low reset
//     bus.en          enable; low freezes dout, clears the qualification
//                     counters and holds the prescaler at zero
//     bus.din         raw asynchronous inputs
//     bus.dout        debounced levels (registered)
//     bus.rise        one-clock pulse when dout[i] goes 0->1
//     bus.fall        one-clock pulse when dout[i] goes 1->0
//     bus.sample_tick registered copy of the internal sample tick
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int N_CH           = 2,
  parameter int CLK_DIV        = 100,
  parameter int STABLE_SAMPLES = 4,
  parameter int RST_VAL        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  debounce_bank_if.slave    bus
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  // Prescaler needs at least one bit even when CLK_DIV is 1 (it then simply
  // stays at zero and the tick is permanently asserted while enabled).
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  // Qualification counter; one spare bit so STABLE_SAMPLES == 1 still has a
  // legal (one-bit) counter.
  localparam int CW = $clog2(STABLE_SAMPLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic          RST_BIT = (RST_VAL != 0);
  localparam logic [N_CH-1:0] RST_VEC = {N_CH{RST_BIT}};

  // -------------------------------------------------------------------------
  // Sample-tick prescaler
  // -------------------------------------------------------------------------
  logic [PW-1:0] div_cnt_reg;
  logic          tick;
  logic          sample_tick_reg;

  // The tick is combinational so the filter acts on the same edge at which
  // the prescaler wraps; sample_tick is its registered image and therefore
  // lines up with the cycle in which an updated dout first becomes visible.
  assign tick = bus.en && (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      sample_tick_reg <= 1'b0;
    end else begin
      sample_tick_reg <= tick;
      if (!bus.en || tick) begin
        div_cnt_reg <= '0;
      end else begin
        div_cnt_reg <= div_cnt_reg + PW'(1);
      end
    end
  end

  assign bus.sample_tick = sample_tick_reg;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser, free running regardless of en so that the filter
  // sees an up-to-date level as soon as it is enabled again.
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] s1_reg;
  logic [N_CH-1:0] s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= RST_VEC;
      s2_reg <= RST_VEC;
    end else begin
      s1_reg <= bus.din;
      s2_reg <= s1_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel stability filter and edge strobes
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] dout_vec;
  logic [N_CH-1:0] rise_vec;
  logic [N_CH-1:0] fall_vec;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CW-1:0] cnt_reg;
      logic          dout_reg;
      logic          rise_reg;
      logic          fall_reg;
      logic          differ;

      assign differ = s2_reg[gi] ^ dout_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          dout_reg <= RST_BIT;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          // Strobes live for exactly one cycle unless re-armed below.
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (!bus.en) begin
            // Disabling throws away any partial qualification; the level
            // itself is held.
            cnt_reg <= '0;
          end else if (tick) begin
            if (!differ) begin
              // Any sample agreeing with the current level restarts the
              // qualification: this is what rejects bounces.
              cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              dout_reg <= s2_reg[gi];
              cnt_reg  <= '0;
              rise_reg <= s2_reg[gi];
              fall_reg <= ~s2_reg[gi];
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
        end
      end

      assign dout_vec[gi] = dout_reg;
      assign rise_vec[gi] = rise_reg;
      assign fall_vec[gi] = fall_reg;
    end
  endgenerate

  assign bus.dout = dout_vec;
  assign bus.rise = rise_vec;
  assign bus.fall = fall_vec;

endmodule : debounce_bank

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Three debounce banks share one stimulus stream:
//     inst 0: CLK_DIV=4, STABLE_SAMPLES=3, RST_VAL=0 (main configuration)
//     inst 1: CLK_DIV=1, STABLE_SAMPLES=1, RST_VAL=0 (fastest corner)
//     inst 2: CLK_DIV=4, STABLE_SAMPLES=3, RST_VAL=1 (inverted idle level)
//   A behavioural model keeps, per channel, the list of levels seen at each
//   sample instant since the last clear and switches the expected level once
//   the most recent STABLE_SAMPLES of them all disagree with it.
//   Inputs change 2 time units after the falling edge; outputs are compared
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] din;

  always #5 clk = ~clk;

  debounce_bank_if #(.N_CH(2)) bus0 ();
  debounce_bank_if #(.N_CH(2)) bus1 ();
  debounce_bank_if #(.N_CH(2)) bus2 ();

  assign bus0.en  = en;
  assign bus0.din = din;
  assign bus1.en  = en;
  assign bus1.din = din;
  assign bus2.en  = en;
  assign bus2.din = din;

  debounce_bank #(.N_CH(2), .CLK_DIV(4), .STABLE_SAMPLES(3), .RST_VAL(0)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  debounce_bank #(.N_CH(2), .CLK_DIV(1), .STABLE_SAMPLES(1), .RST_VAL(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  debounce_bank #(.N_CH(2), .CLK_DIV(4), .STABLE_SAMPLES(3), .RST_VAL(1)) u_rv1 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // Observed outputs gathered by instance index
  logic [1:0] o_dout [3];
  logic [1:0] o_rise [3];
  logic [1:0] o_fall [3];
  logic       o_tick [3];

  assign o_dout[0] = bus0.dout;  assign o_rise[0] = bus0.rise;
  assign o_fall[0] = bus0.fall;  assign o_tick[0] = bus0.sample_tick;
  assign o_dout[1] = bus1.dout;  assign o_rise[1] = bus1.rise;
  assign o_fall[1] = bus1.fall;  assign o_tick[1] = bus1.sample_tick;
  assign o_dout[2] = bus2.dout;  assign o_rise[2] = bus2.rise;
  assign o_fall[2] = bus2.fall;  assign o_tick[2] = bus2.sample_tick;

  function automatic int div_of(input int d);
    return (d == 1) ? 1 : 4;
  endfunction
  function automatic int ss_of(input int d);
    return (d == 1) ? 1 : 3;
  endfunction
  function automatic logic rv_of(input int d);
    return (d == 2);
  endfunction

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [1:0]  m_s1   [3];
  logic [1:0]  m_s2   [3];
  logic [1:0]  e_dout [3];
  logic [1:0]  e_rise [3];
  logic [1:0]  e_fall [3];
  logic        e_tick [3];
  int          m_k    [3];      // consecutive enabled edges since last clear
  int          nsamp  [3][2];   // samples collected since last clear
  int unsigned hist   [3][2];   // sample history, newest in bit 0

  always @(posedge clk) begin : model
    logic [1:0]  s2_old;
    int unsigned mask;
    int unsigned want;
    logic        samp;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_s1[d]   = {2{rv_of(d)}};
        m_s2[d]   = {2{rv_of(d)}};
        e_dout[d] = {2{rv_of(d)}};
        e_rise[d] = 2'b00;
        e_fall[d] = 2'b00;
        e_tick[d] = 1'b0;
        m_k[d]    = 0;
        for (int c = 0; c < 2; c++) begin
          nsamp[d][c] = 0;
          hist[d][c]  = 0;
        end
      end else begin
        s2_old    = m_s2[d];
        m_s2[d]   = m_s1[d];
        m_s1[d]   = din;
        e_rise[d] = 2'b00;
        e_fall[d] = 2'b00;
        e_tick[d] = 1'b0;
        if (!en) begin
          m_k[d] = 0;
          for (int c = 0; c < 2; c++) begin
            nsamp[d][c] = 0;
            hist[d][c]  = 0;
          end
        end else begin
          m_k[d]++;
          if (m_k[d] % div_of(d) == 0) begin
            e_tick[d] = 1'b1;
            mask = (32'd1 << ss_of(d)) - 1;
            for (int c = 0; c < 2; c++) begin
              samp = s2_old[c];
              hist[d][c]  = (hist[d][c] << 1) | {31'd0, samp};
              nsamp[d][c] = nsamp[d][c] + 1;
              want = e_dout[d][c] ? 32'd0 : mask;
              if (nsamp[d][c] >= ss_of(d) && (hist[d][c] & mask) == want) begin
                e_dout[d][c] = ~e_dout[d][c];
                if (e_dout[d][c]) e_rise[d][c] = 1'b1;
                else              e_fall[d][c] = 1'b1;
                nsamp[d][c] = 0;
                hist[d][c]  = 0;
              end
            end
          end
        end
      end
    end
  end

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check_eq($sformatf("dout[%0d]", d), 32'(o_dout[d]), 32'(e_dout[d]));
        check_eq($sformatf("rise[%0d]", d), 32'(o_rise[d]), 32'(e_rise[d]));
        check_eq($sformatf("fall[%0d]", d), 32'(o_fall[d]), 32'(e_fall[d]));
        check_eq($sformatf("tick[%0d]", d), 32'(o_tick[d]), 32'(e_tick[d]));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // Advance n falling edges and land just after the edge, where inputs
  // may be changed and settled outputs read.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  int rise_cnt;

  task automatic cyc_count_rise0(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (bus0.rise[0]) rise_cnt++;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_eq("rst_now_dout0", 32'(bus0.dout), 32'h0);
    check_eq("rst_now_dout2", 32'(bus2.dout), 32'h3);
    check_eq("rst_now_fall0", 32'(bus0.fall), 32'h0);
    check_eq("rst_now_rise2", 32'(bus2.rise), 32'h0);
    cyc(1);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int seen;
    int tick_cnt;
    int hold;
    rst_n = 1'b0;
    en    = 1'b1;
    din   = 2'b11;
    @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset with both inputs high
    cyc(3);
    check_eq("rst_dout0", 32'(bus0.dout), 32'h0);
    check_eq("rst_rise0", 32'(bus0.rise), 32'h0);
    check_eq("rst_dout2", 32'(bus2.dout), 32'h3);
    rst_n = 1'b1;
    cyc(11);
    check_eq("pre_tick3_dout0", 32'(bus0.dout), 32'h0);
    cyc(1);
    check_eq("tick3_dout0", 32'(bus0.dout), 32'h3);
    check_eq("tick3_rise0", 32'(bus0.rise), 32'h3);
    cyc(1);
    check_eq("tick3_rise0_clr", 32'(bus0.rise), 32'h0);

    // Fall everywhere, including the RST_VAL=1 instance
    din = 2'b00;
    cyc(20);
    check_eq("low_dout0", 32'(bus0.dout), 32'h0);
    check_eq("low_dout2", 32'(bus2.dout), 32'h0);

    // Clean step on channel 0; fast instance has a 3-clock latency
    din = 2'b01;
    cyc(2);
    check_eq("fast_lat2", 32'(bus1.dout), 32'h0);
    check_eq("fast_tick", 32'(bus1.sample_tick), 32'h1);
    cyc(1);
    check_eq("fast_lat3", 32'(bus1.dout), 32'h1);
    cyc(20);
    check_eq("step_dout0", 32'(bus0.dout), 32'h1);

    // Bounce: 2 ticks high, 1 tick low, then a long high run
    din = 2'b00;
    cyc(20);
    rise_cnt = 0;
    din = 2'b01;
    cyc_count_rise0(8);
    din = 2'b00;
    cyc_count_rise0(4);
    din = 2'b01;
    cyc_count_rise0(24);
    check_eq("bounce_rises", 32'(rise_cnt), 32'h1);

    // Simultaneous opposite changes
    din = 2'b10;
    cyc(24);
    check_eq("simul_pre", 32'(bus0.dout), 32'h2);
    din  = 2'b01;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cyc(1);
      if (bus0.rise != 2'b00 || bus0.fall != 2'b00) seen = 1;
    end
    check_eq("simul_seen", 32'(seen), 32'h1);
    check_eq("simul_dout", 32'(bus0.dout), 32'h1);
    check_eq("simul_rise", 32'(bus0.rise), 32'h1);
    check_eq("simul_fall", 32'(bus0.fall), 32'h2);

    // Enable dropped after two qualifying ticks
    din = 2'b00;
    cyc(24);
    din = 2'b01;
    cyc(2);
    tick_cnt = 0;
    for (int i = 0; i < 20 && tick_cnt < 2; i++) begin
      cyc(1);
      if (bus0.sample_tick) tick_cnt++;
    end
    check_eq("en_two_ticks", 32'(tick_cnt), 32'h2);
    check_eq("en_pre_dout", 32'(bus0.dout), 32'h0);
    en   = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus0.sample_tick) seen = 1;
    end
    check_eq("en_off_silent", 32'(seen), 32'h0);
    en = 1'b1;
    cyc(8);
    check_eq("en_requal_2", 32'(bus0.dout), 32'h0);
    cyc(4);
    check_eq("en_requal_3", 32'(bus0.dout), 32'h1);
    check_eq("en_requal_rise", 32'(bus0.rise), 32'h1);

    // Reset in the middle of a fall qualification
    din = 2'b00;
    cyc(6);
    reset_pulse();
    cyc(20);

    // Randomised bouncing, enable gaps and occasional resets
    for (int it = 0; it < 1200; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse();
      end
      en   = ($urandom_range(0, 9) != 0);
      din  = 2'($urandom_range(0, 3));
      hold = (($urandom_range(0, 3) == 0)) ? int'($urandom_range(10, 24))
                                            : int'($urandom_range(1, 6));
      cyc(hold);
    end
    en = 1'b1;
    cyc(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debounce_bank
